mips_bus_lsu: RTL and testbench

//  Parametrised two-channel bus interface unit: arbitrates instruction fetches and data loads/stores onto one Avalon-MM master.

---
 rtl/mips_bus_lsu.sv | 256 +++++++++++++++++++++++++
 tb/tb_mips_bus_lsu.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_lsu
// Description : Fetch/data bus interface unit onto a single Avalon-MM master
//               with lane steering, endianness, alignment checks and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_lsu #(
    parameter int BIG_ENDIAN     = 1,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_addr,
    output logic        i_resp_valid,
    output logic [31:0] i_resp_data,
    output logic        i_resp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic        d_resp_err,
    output logic        busy,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_BUS   = 2'd1;
    localparam logic [1:0]  c_ST_RDATA = 2'd2;
    localparam logic [1:0]  c_ST_RESP  = 2'd3;

    localparam logic [1:0]  c_SZ_BYTE  = 2'b00;
    localparam logic [1:0]  c_SZ_HALF  = 2'b01;
    localparam logic [1:0]  c_SZ_WORD  = 2'b10;

    localparam bit          c_BE       = (BIG_ENDIAN != 0);
    localparam bit          c_TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] c_TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    function automatic logic [31:0] f_swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [15:0] f_swap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  w_next;

    logic        r_port;        // 1: data port owns the transaction
    logic        r_we;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_wait_cnt;
    logic [31:0] r_resp_data;
    logic        r_resp_err;
    logic        r_last_i;

    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_accept;
    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic        w_we;
    logic        w_signed;
    logic        w_bad;
    logic        w_bus_ack;
    logic        w_timeout;

    logic [15:0] w_st_half;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_data;

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_hraw;
    logic [15:0] w_ld_half;
    logic [31:0] w_load;

    // Round-robin favours whichever port was not served last; r_last_i
    // resets high so the data port wins the first contest.
    assign w_grant_d = d_req_valid && (!i_req_valid || (ARB_MODE == 0) || r_last_i);
    assign w_grant_i = i_req_valid && !w_grant_d;
    assign w_accept  = (r_state == c_ST_IDLE) && !reset && (w_grant_d || w_grant_i);

    assign w_addr    = w_grant_d ? d_addr : i_addr;
    assign w_size    = w_grant_d ? d_size : c_SZ_WORD;
    assign w_we      = w_grant_d && d_we;
    assign w_signed  = w_grant_d && d_signed;
    assign w_bad     = (w_size == 2'b11)
                    || ((w_size == c_SZ_HALF) && w_addr[0])
                    || ((w_size == c_SZ_WORD) && (w_addr[1:0] != 2'b00));

    assign w_bus_ack = (r_state == c_ST_BUS) && !waitrequest;
    assign w_timeout = c_TO_EN && (r_state == c_ST_BUS) && waitrequest
                    && (r_wait_cnt == c_TO_LAST);

    always_comb begin
        w_st_half = c_BE ? f_swap16(d_wdata[15:0]) : d_wdata[15:0];
        w_st_be   = 4'b1111;
        w_st_data = c_BE ? f_swap32(d_wdata) : d_wdata;
        case (w_size)
            c_SZ_BYTE: begin
                w_st_be   = 4'b0001 << w_addr[1:0];
                w_st_data = {4{d_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_st_be   = w_addr[1] ? 4'b1100 : 4'b0011;
                w_st_data = {w_st_half, w_st_half};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_ld_byte = 8'(readdata >> {r_addr[1:0], 3'b000});
        w_ld_hraw = r_addr[1] ? readdata[31:16] : readdata[15:0];
        w_ld_half = c_BE ? f_swap16(w_ld_hraw) : w_ld_hraw;
        w_load    = c_BE ? f_swap32(readdata) : readdata;
        case (r_size)
            c_SZ_BYTE: w_load = r_signed ? {{24{w_ld_byte[7]}}, w_ld_byte}
                                         : {24'd0, w_ld_byte};
            c_SZ_HALF: w_load = r_signed ? {{16{w_ld_half[15]}}, w_ld_half}
                                         : {16'd0, w_ld_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_bad ? c_ST_RESP : c_ST_BUS;
                end
            end
            c_ST_BUS: begin
                if (w_bus_ack) begin
                    w_next = r_we ? c_ST_RESP : c_ST_RDATA;
                end else if (w_timeout) begin
                    w_next = c_ST_RESP;
                end
            end
            c_ST_RDATA: w_next = c_ST_RESP;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        i_req_ready  = 1'b0;
        d_req_ready  = 1'b0;
        i_resp_valid = 1'b0;
        i_resp_data  = 32'd0;
        i_resp_err   = 1'b0;
        d_resp_valid = 1'b0;
        d_resp_data  = 32'd0;
        d_resp_err   = 1'b0;
        read         = 1'b0;
        write        = 1'b0;
        address      = 32'd0;
        byteenable   = 4'd0;
        writedata    = 32'd0;
        busy         = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_IDLE: begin
                d_req_ready = w_grant_d && !reset;
                i_req_ready = w_grant_i && !reset;
            end
            c_ST_BUS: begin
                read       = !r_we;
                write      = r_we;
                address    = {r_addr[31:2], 2'b00};
                byteenable = r_be;
                writedata  = r_we ? r_bus_wdata : 32'd0;
            end
            c_ST_RESP: begin
                if (r_port) begin
                    d_resp_valid = 1'b1;
                    d_resp_data  = r_resp_data;
                    d_resp_err   = r_resp_err;
                end else begin
                    i_resp_valid = 1'b1;
                    i_resp_data  = r_resp_data;
                    i_resp_err   = r_resp_err;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_port      <= 1'b0;
            r_we        <= 1'b0;
            r_signed    <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= 32'd0;
            r_be        <= 4'd0;
            r_bus_wdata <= 32'd0;
            r_wait_cnt  <= 32'd0;
            r_resp_data <= 32'd0;
            r_resp_err  <= 1'b0;
            r_last_i    <= 1'b1;
        end else begin
            if (w_accept) begin
                r_port      <= w_grant_d;
                r_we        <= w_we;
                r_signed    <= w_signed;
                r_size      <= w_size;
                r_addr      <= w_addr;
                r_be        <= w_st_be;
                r_bus_wdata <= w_st_data;
                r_wait_cnt  <= 32'd0;
                r_resp_data <= 32'd0;
                r_resp_err  <= w_bad;
                r_last_i    <= w_grant_i;
            end
            if ((r_state == c_ST_BUS) && waitrequest) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
            if (w_timeout) begin
                r_resp_err <= 1'b1;
            end
            if (r_state == c_ST_RDATA) begin
                r_resp_data <= w_load;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_lsu
// Description : Scoreboard bench for mips_bus_lsu; instance 0 uses fixed
//               priority / 16-cycle timeout, instance 1 round-robin / 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_bus_lsu;

    typedef struct {
        bit          port;
        logic [31:0] data;
        bit          err;
        int          cyc;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          ncyc;
    } bus_t;

    localparam logic [1:0] c_B = 2'b00;
    localparam logic [1:0] c_H = 2'b01;
    localparam logic [1:0] c_W = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid [2];
    logic        i_req_ready [2];
    logic [31:0] i_addr      [2];
    logic        i_resp_valid[2];
    logic [31:0] i_resp_data [2];
    logic        i_resp_err  [2];
    logic        d_req_valid [2];
    logic        d_req_ready [2];
    logic [31:0] d_addr      [2];
    logic        d_we        [2];
    logic [1:0]  d_size      [2];
    logic        d_signed    [2];
    logic [31:0] d_wdata     [2];
    logic        d_resp_valid[2];
    logic [31:0] d_resp_data [2];
    logic        d_resp_err  [2];
    logic        busy        [2];
    logic [31:0] address     [2];
    logic        read        [2];
    logic        write       [2];
    logic        waitrequest [2];
    logic [31:0] writedata   [2];
    logic [3:0]  byteenable  [2];
    logic [31:0] readdata    [2];

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_fail = 0;
    int    stall_req [2];
    int    wcnt [2] = '{0, 0};
    int    scnt [2] = '{0, 0};
    resp_t exp_resp  [2][$];
    bus_t  exp_bus   [2][$];
    bit    exp_grant [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mips_bus_lsu #(
            .BIG_ENDIAN    (1),
            .ARB_MODE      (g),
            .TIMEOUT_CYCLES(g == 0 ? 16 : 4)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .i_req_valid (i_req_valid[g]),
            .i_req_ready (i_req_ready[g]),
            .i_addr      (i_addr[g]),
            .i_resp_valid(i_resp_valid[g]),
            .i_resp_data (i_resp_data[g]),
            .i_resp_err  (i_resp_err[g]),
            .d_req_valid (d_req_valid[g]),
            .d_req_ready (d_req_ready[g]),
            .d_addr      (d_addr[g]),
            .d_we        (d_we[g]),
            .d_size      (d_size[g]),
            .d_signed    (d_signed[g]),
            .d_wdata     (d_wdata[g]),
            .d_resp_valid(d_resp_valid[g]),
            .d_resp_data (d_resp_data[g]),
            .d_resp_err  (d_resp_err[g]),
            .busy        (busy[g]),
            .address     (address[g]),
            .read        (read[g]),
            .write       (write[g]),
            .waitrequest (waitrequest[g]),
            .writedata   (writedata[g]),
            .byteenable  (byteenable[g]),
            .readdata    (readdata[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Slave model, bus monitor, grant monitor and response monitor.
    always @(negedge clk) begin
        resp_t r;
        bus_t  b;
        bit    eg;
        for (int g = 0; g < 2; g++) begin
            if ((d_req_valid[g] && d_req_ready[g]) || (i_req_valid[g] && i_req_ready[g])) begin
                chk($sformatf("g%0d grant_exclusive", g),
                    32'(d_req_valid[g] && d_req_ready[g] && i_req_valid[g] && i_req_ready[g]), 32'd0);
                if (exp_grant[g].size() == 0) begin
                    fail($sformatf("g%0d grant", g), "got an accept, expected none");
                end else begin
                    eg = exp_grant[g].pop_front();
                    chk($sformatf("g%0d grant_is_data", g), 32'(d_req_valid[g] && d_req_ready[g]), 32'(eg));
                end
            end

            if (read[g] || write[g]) begin
                waitrequest[g] = (wcnt[g] < stall_req[g]);
                if (waitrequest[g]) wcnt[g]++;
                scnt[g]++;
                chk($sformatf("g%0d bus_both_strobes", g), 32'(read[g] && write[g]), 32'd0);
                if (exp_bus[g].size() == 0) begin
                    if (scnt[g] == 1) fail($sformatf("g%0d bus", g), "got a strobe, expected none");
                end else begin
                    b = exp_bus[g][0];
                    chk($sformatf("g%0d bus_write", g), 32'(write[g]), 32'(b.we));
                    chk($sformatf("g%0d bus_address", g), address[g], b.addr);
                    chk($sformatf("g%0d bus_byteenable", g), 32'(byteenable[g]), 32'(b.be));
                    if (b.we) chk($sformatf("g%0d bus_writedata", g), writedata[g], b.wdata);
                end
            end else begin
                waitrequest[g] = 1'b0;
                if (scnt[g] != 0) begin
                    if (exp_bus[g].size() != 0) begin
                        b = exp_bus[g].pop_front();
                        chk($sformatf("g%0d bus_strobe_cycles", g), 32'(scnt[g]), 32'(b.ncyc));
                    end
                    scnt[g] = 0;
                    wcnt[g] = 0;
                end
            end

            if (i_resp_valid[g] || d_resp_valid[g]) begin
                chk($sformatf("g%0d resp_exclusive", g), 32'(i_resp_valid[g] && d_resp_valid[g]), 32'd0);
                if (exp_resp[g].size() == 0) begin
                    fail($sformatf("g%0d resp", g), "got a response pulse, expected none");
                end else begin
                    r = exp_resp[g].pop_front();
                    chk($sformatf("g%0d resp_port", g), 32'(d_resp_valid[g]), 32'(r.port));
                    chk($sformatf("g%0d resp_data", g), r.port ? d_resp_data[g] : i_resp_data[g], r.data);
                    chk($sformatf("g%0d resp_err", g), 32'(r.port ? d_resp_err[g] : i_resp_err[g]), 32'(r.err));
                    chk($sformatf("g%0d resp_cycle", g), 32'(cyc), 32'(r.cyc));
                end
            end else begin
                chk($sformatf("g%0d resp_idle_zero", g),
                    i_resp_data[g] | d_resp_data[g] | {30'd0, i_resp_err[g], d_resp_err[g]}, 32'd0);
            end
        end
    end

    task automatic push_resp(input int g, input bit port, input logic [31:0] data, input bit err, input int c);
        resp_t r;
        r.port = port; r.data = data; r.err = err; r.cyc = c;
        exp_resp[g].push_back(r);
    endtask

    task automatic push_bus(input int g, input bit we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wd, input int ncyc);
        bus_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wd; b.ncyc = ncyc;
        exp_bus[g].push_back(b);
    endtask

    task automatic issue(input int g, input bit dport, input logic [31:0] addr, input bit we,
                         input logic [1:0] size, input bit sgn, input logic [31:0] wdata, output int t);
        exp_grant[g].push_back(dport);
        @(posedge clk); #1;
        if (dport) begin
            d_req_valid[g] = 1'b1; d_addr[g] = addr; d_we[g] = we;
            d_size[g] = size; d_signed[g] = sgn; d_wdata[g] = wdata;
        end else begin
            i_req_valid[g] = 1'b1; i_addr[g] = addr;
        end
        t = -1;
        for (int k = 0; k < 20 && t < 0; k++) begin
            @(negedge clk);
            if (dport ? d_req_ready[g] : i_req_ready[g]) t = cyc;
        end
        if (t < 0) fail($sformatf("g%0d accept", g), "ready never rose within 20 cycles");
        @(posedge clk); #1;
        d_req_valid[g] = 1'b0;
        i_req_valid[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        for (int c = 0; c < 40 && exp_resp[g].size() != 0; c++) @(negedge clk);
        if (exp_resp[g].size() != 0) fail($sformatf("g%0d drain", g), "response still pending after 40 cycles");
    endtask

    task automatic run(input int g, input bit dport, input logic [31:0] addr, input bit we,
                       input logic [1:0] size, input bit sgn, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int stall, input bit bus,
                       input logic [3:0] be, input logic [31:0] bwd, input int ncyc,
                       input logic [31:0] rdat, input bit rerr, input int lat);
        int t;
        readdata[g]  = rdata;
        stall_req[g] = stall;
        issue(g, dport, addr, we, size, sgn, wdata, t);
        if (t >= 0) begin
            if (bus) push_bus(g, we, {addr[31:2], 2'b00}, be, bwd, ncyc);
            push_resp(g, dport, rdat, rerr, t + lat);
        end
        drain(g);
        stall_req[g] = 0;
    endtask

    // Both ports request continuously; seq[k] is the expected winner (1 = data)
    // of the k-th acceptance; the data request is withdrawn after ndrop accepts.
    task automatic arb(input int g, input logic [3:0] seq, input int ndrop);
        int n = 0;
        for (int k = 0; k < 4; k++) exp_grant[g].push_back(seq[k]);
        @(posedge clk); #1;
        d_req_valid[g] = 1'b1; d_addr[g] = 32'h1; d_size[g] = c_W; d_we[g] = 1'b0;
        i_req_valid[g] = 1'b1; i_addr[g] = 32'h2;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if ((d_req_valid[g] && d_req_ready[g]) || (i_req_valid[g] && i_req_ready[g])) begin
                push_resp(g, seq[n], 32'd0, 1'b1, cyc + 1);
                n++;
                @(posedge clk); #1;
                if (n >= ndrop) d_req_valid[g] = 1'b0;
                if (n >= 4) i_req_valid[g] = 1'b0;
            end
        end
        if (n < 4) fail($sformatf("g%0d arb", g), $sformatf("got %0d accepts, expected 4", n));
        d_req_valid[g] = 1'b0;
        i_req_valid[g] = 1'b0;
        drain(g);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            i_req_valid[g] = 1'b0; i_addr[g] = 32'd0;
            d_req_valid[g] = 1'b0; d_addr[g] = 32'd0; d_we[g] = 1'b0;
            d_size[g] = 2'd0; d_signed[g] = 1'b0; d_wdata[g] = 32'd0;
            readdata[g] = 32'd0; stall_req[g] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d reset_busy", g), 32'(busy[g]), 32'd0);
            chk($sformatf("g%0d reset_strobes", g), 32'({read[g], write[g]}), 32'd0);
            chk($sformatf("g%0d reset_ready", g), 32'({i_req_ready[g], d_req_ready[g]}), 32'd0);
            chk($sformatf("g%0d reset_address", g), address[g], 32'd0);
            chk($sformatf("g%0d reset_be", g), 32'(byteenable[g]), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        //  g  D  addr          we size sgn wdata         rdata         st bus be       bwd           n  result        err lat
        run(0, 0, 32'hBFC00000, 0, c_W, 0, 32'h0,        32'h78563412, 0, 1, 4'b1111, 32'h0,        1, 32'h12345678, 0, 3);
        run(0, 1, 32'h00000103, 0, c_B, 1, 32'h0,        32'h80FFFFFF, 0, 1, 4'b1000, 32'h0,        1, 32'hFFFFFF80, 0, 3);
        run(0, 1, 32'h00000103, 0, c_B, 0, 32'h0,        32'h80FFFFFF, 0, 1, 4'b1000, 32'h0,        1, 32'h00000080, 0, 3);
        run(0, 1, 32'h00000102, 1, c_H, 0, 32'h0000BEEF, 32'h0,        0, 1, 4'b1100, 32'hEFBEEFBE, 1, 32'h0,        0, 2);
        run(0, 1, 32'h00000204, 1, c_W, 0, 32'h11223344, 32'h0,        0, 1, 4'b1111, 32'h44332211, 1, 32'h0,        0, 2);
        run(0, 1, 32'h00000301, 1, c_B, 0, 32'h000000A5, 32'h0,        0, 1, 4'b0010, 32'hA5A5A5A5, 1, 32'h0,        0, 2);
        run(0, 1, 32'h00000402, 0, c_H, 0, 32'h0,        32'h34129999, 0, 1, 4'b1100, 32'h0,        1, 32'h00001234, 0, 3);
        run(0, 1, 32'h00000400, 0, c_H, 1, 32'h0,        32'h00000080, 0, 1, 4'b0011, 32'h0,        1, 32'hFFFF8000, 0, 3);
        run(0, 1, 32'h00000200, 0, c_W, 0, 32'h0,        32'hAABBCCDD, 3, 1, 4'b1111, 32'h0,        4, 32'hDDCCBBAA, 0, 6);
        run(0, 1, 32'h00000101, 0, c_W, 0, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, 1);
        run(0, 1, 32'h00000000, 0, 2'b11, 0, 32'h0,      32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, 1);
        run(0, 0, 32'h00000002, 0, c_W, 0, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, 1);
        run(0, 1, 32'h00000101, 1, c_H, 0, 32'h1234,     32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, 1);

        arb(1, 4'b0101, 4);
        arb(0, 4'b0111, 3);

        run(1, 1, 32'h00000000, 0, c_W, 0, 32'h0,        32'hDEADBEEF, 10, 1, 4'b1111, 32'h0,       4, 32'h0,        1, 5);

        // Reset while the slave is stalling: three strobe cycles, then silence.
        stall_req[0] = 10;
        issue(0, 1, 32'h00000500, 0, c_W, 0, 32'h0, t);
        if (t >= 0) push_bus(0, 1'b0, 32'h00000500, 4'b1111, 32'h0, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("g0 busy_after_reset", 32'(busy[0]), 32'd0);
        chk("g0 read_after_reset", 32'(read[0]), 32'd0);
        stall_req[0] = 0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d resp_queue_left", g), 32'(exp_resp[g].size()), 32'd0);
            chk($sformatf("g%0d bus_queue_left", g), 32'(exp_bus[g].size()), 32'd0);
            chk($sformatf("g%0d grant_queue_left", g), 32'(exp_grant[g].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
